// File: rtl/router_fsm_if.sv
// rtl/router_fsm_if.sv - router FSM control/status bundle
// Purpose: groups the router FSM's packet, FIFO and register-stage signals.
// Ports (signals):
//   pkt_valid, data_in[1:0]              source byte stream and header address
//   fifo_full, fifo_empty_0..2           FIFO status flags
//   soft_reset_0..2                      per-channel timeout resets
//   parity_done, low_pkt_valid           register-stage status
//   detect_add, lfd_state, ld_state,
//   laf_state, full_state                state indicators
//   write_enb_reg, rst_int_reg, busy     register-stage controls and source stall
// Modports: master = environment side, slave = FSM side.
interface router_fsm_if;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       write_enb_reg;
  logic       rst_int_reg;
  logic       busy;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2, parity_done, low_pkt_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
           write_enb_reg, rst_int_reg, busy
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2, parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
           write_enb_reg, rst_int_reg, busy
  );
endinterface

// File: rtl/router_fsm.sv
// rtl/router_fsm.sv - router packet-sequencing FSM
// Purpose: sequences header decode, payload load, FIFO-full stall and parity
// check for a 3-channel router; outputs are registered copies of the state decode.
// Ports:
//   clock   rising-edge clock
//   resetn  synchronous active-low reset
//   bus     router_fsm_if.slave control/status bundle
module router_fsm (
  input  logic         clock,
  input  logic         resetn,
  router_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_addr;
  logic       w_empty_hdr;
  logic       w_empty_addr;
  logic       w_soft_reset;

  logic r_detect_add, r_lfd_state, r_ld_state, r_laf_state, r_full_state;
  logic r_write_enb_reg, r_rst_int_reg, r_busy;

  // Header decision uses the live address; waiting and soft reset use the latched one.
  always_comb begin
    w_empty_hdr  = 1'b0;
    w_empty_addr = 1'b0;
    w_soft_reset = 1'b0;
    case (bus.data_in)
      2'd0:    w_empty_hdr = bus.fifo_empty_0;
      2'd1:    w_empty_hdr = bus.fifo_empty_1;
      2'd2:    w_empty_hdr = bus.fifo_empty_2;
      default: w_empty_hdr = 1'b0;
    endcase
    case (r_addr)
      2'd0: begin w_empty_addr = bus.fifo_empty_0; w_soft_reset = bus.soft_reset_0; end
      2'd1: begin w_empty_addr = bus.fifo_empty_1; w_soft_reset = bus.soft_reset_1; end
      2'd2: begin w_empty_addr = bus.fifo_empty_2; w_soft_reset = bus.soft_reset_2; end
      default: begin w_empty_addr = 1'b0; w_soft_reset = 1'b0; end
    endcase
  end

  always_comb begin
    w_next_state = DECODE_ADDRESS;
    if (w_soft_reset) begin
      w_next_state = DECODE_ADDRESS;
    end else begin
      case (r_state)
        DECODE_ADDRESS: begin
          if (bus.pkt_valid && bus.data_in != 2'd3)
            w_next_state = w_empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          else
            w_next_state = DECODE_ADDRESS;
        end
        WAIT_TILL_EMPTY:    w_next_state = w_empty_addr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        LOAD_FIRST_DATA:    w_next_state = LOAD_DATA;
        LOAD_DATA: begin
          if (bus.fifo_full)       w_next_state = FIFO_FULL_STATE;
          else if (!bus.pkt_valid) w_next_state = LOAD_PARITY;
          else                     w_next_state = LOAD_DATA;
        end
        FIFO_FULL_STATE:    w_next_state = bus.fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
        LOAD_AFTER_FULL: begin
          if (bus.parity_done)        w_next_state = DECODE_ADDRESS;
          else if (bus.low_pkt_valid) w_next_state = LOAD_PARITY;
          else                        w_next_state = LOAD_DATA;
        end
        LOAD_PARITY:        w_next_state = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: w_next_state = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        default:            w_next_state = DECODE_ADDRESS;
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they track r_state exactly.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state         <= DECODE_ADDRESS;
      r_addr          <= 2'd0;
      r_detect_add    <= 1'b1;
      r_lfd_state     <= 1'b0;
      r_ld_state      <= 1'b0;
      r_laf_state     <= 1'b0;
      r_full_state    <= 1'b0;
      r_write_enb_reg <= 1'b0;
      r_rst_int_reg   <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == DECODE_ADDRESS && bus.pkt_valid)
        r_addr <= bus.data_in;
      r_detect_add    <= (w_next_state == DECODE_ADDRESS);
      r_lfd_state     <= (w_next_state == LOAD_FIRST_DATA);
      r_ld_state      <= (w_next_state == LOAD_DATA);
      r_laf_state     <= (w_next_state == LOAD_AFTER_FULL);
      r_full_state    <= (w_next_state == FIFO_FULL_STATE);
      r_rst_int_reg   <= (w_next_state == CHECK_PARITY_ERROR);
      r_write_enb_reg <= (w_next_state == LOAD_DATA) || (w_next_state == LOAD_PARITY) ||
                         (w_next_state == LOAD_AFTER_FULL);
      r_busy          <= (w_next_state != DECODE_ADDRESS) && (w_next_state != LOAD_DATA);
    end
  end

  assign bus.detect_add    = r_detect_add;
  assign bus.lfd_state     = r_lfd_state;
  assign bus.ld_state      = r_ld_state;
  assign bus.laf_state     = r_laf_state;
  assign bus.full_state    = r_full_state;
  assign bus.write_enb_reg = r_write_enb_reg;
  assign bus.rst_int_reg   = r_rst_int_reg;
  assign bus.busy          = r_busy;

endmodule

// File: tb/tb_router_fsm.sv
// tb/tb_router_fsm.sv - directed self-checking bench for router_fsm
module tb_router_fsm;
  logic clock;
  logic resetn;
  int   tests;
  int   fails;

  router_fsm_if bus();

  router_fsm dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {detect_add, lfd, ld, laf, full, write_enb_reg, rst_int_reg, busy}
  localparam logic [7:0] S_DEC  = 8'h80;
  localparam logic [7:0] S_LFD  = 8'h41;
  localparam logic [7:0] S_LD   = 8'h24;
  localparam logic [7:0] S_LAF  = 8'h15;
  localparam logic [7:0] S_FULL = 8'h09;
  localparam logic [7:0] S_LP   = 8'h05;
  localparam logic [7:0] S_CPE  = 8'h03;
  localparam logic [7:0] S_WAIT = 8'h01;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] expected);
    logic [7:0] observed;
    observed = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy};
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    resetn = 1'b0;
    bus.pkt_valid = 1'b0;     bus.data_in = 2'd0;       bus.fifo_full = 1'b0;
    bus.fifo_empty_0 = 1'b1;  bus.fifo_empty_1 = 1'b1;  bus.fifo_empty_2 = 1'b1;
    bus.soft_reset_0 = 1'b0;  bus.soft_reset_1 = 1'b0;  bus.soft_reset_2 = 1'b0;
    bus.parity_done = 1'b0;   bus.low_pkt_valid = 1'b0;

    step(); step();
    check("reset", S_DEC);
    resetn = 1'b1;

    // Normal packet to channel 1
    bus.data_in = 2'd1; bus.pkt_valid = 1'b1;
    step(); check("hdr1_lfd", S_LFD);
    step(); check("pay1_ld", S_LD);
    for (int i = 0; i < 13; i++) begin
      step(); check("pay1_hold", S_LD);
    end
    bus.pkt_valid = 1'b0;
    step(); check("pkt1_lp", S_LP);
    step(); check("pkt1_cpe", S_CPE);
    step(); check("pkt1_dec", S_DEC);

    // Full stall on channel 0
    bus.data_in = 2'd0; bus.pkt_valid = 1'b1;
    step(); check("hdr0_lfd", S_LFD);
    step(); check("hdr0_ld", S_LD);
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check("full_hold", S_FULL);
    end
    bus.fifo_full = 1'b0;
    step(); check("laf", S_LAF);
    step(); check("laf_to_ld", S_LD);

    // Soft reset of another channel ignored, own channel honoured
    bus.soft_reset_1 = 1'b1;
    step(); check("sr1_ignored", S_LD);
    bus.soft_reset_1 = 1'b0; bus.soft_reset_0 = 1'b1;
    step(); check("sr0_dec", S_DEC);
    bus.soft_reset_0 = 1'b0;

    // Invalid header dropped
    bus.data_in = 2'd3;
    step(); check("addr3_stay_a", S_DEC);
    step(); check("addr3_stay_b", S_DEC);

    // Priority and remaining LAF/CPE branches on channel 0
    bus.data_in = 2'd0;
    step(); check("p_lfd", S_LFD);
    step(); check("p_ld", S_LD);
    bus.pkt_valid = 1'b0; bus.fifo_full = 1'b1;
    step(); check("full_priority", S_FULL);
    bus.fifo_full = 1'b0;
    step(); check("p_laf", S_LAF);
    bus.low_pkt_valid = 1'b1;
    step(); check("laf_low_lp", S_LP);
    bus.low_pkt_valid = 1'b0; bus.fifo_full = 1'b1;
    step(); check("lp_cpe", S_CPE);
    step(); check("cpe_full", S_FULL);
    bus.fifo_full = 1'b0;
    step(); check("p_laf2", S_LAF);
    bus.parity_done = 1'b1;
    step(); check("laf_parity_dec", S_DEC);
    bus.parity_done = 1'b0;

    // Wait for channel 2 to drain
    bus.data_in = 2'd2; bus.pkt_valid = 1'b1; bus.fifo_empty_2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); check("wait_hold", S_WAIT);
    end
    bus.fifo_empty_2 = 1'b1;
    step(); check("wait_lfd", S_LFD);
    step(); check("wait_ld", S_LD);

    // Hard reset mid-stall
    bus.fifo_full = 1'b1;
    step(); check("pre_reset_full", S_FULL);
    resetn = 1'b0;
    step(); check("reset_in_full", S_DEC);
    resetn = 1'b1; bus.fifo_full = 1'b0; bus.pkt_valid = 1'b0;
    step(); check("post_reset_idle", S_DEC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
